// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Decode/issue stage in front of the 32-bit ALU. Accepts one MIPS instruction
// plus its two register-file operands per handshake. It decodes the ALU
// control code, selects and extends the operands, and holds up to two issued
// operations in a small skid queue. The queue head drives the ALU inputs.
//
// Optional feature: define ALU_ISSUE_FWD_EN to add an operand-forwarding port.
// The forwarding value replaces rs_val/rt_val at acceptance.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready depends only on occupancy)
//   instr, rs_val, rt_val instruction word and its rs/rt register values
//   out_valid/out_ready   downstream handshake toward the execute stage
//   alu_a, alu_b, aluc    ALU operands and control code of the queue head
//   wr_reg, wr_en         destination register of the head; wr_en=0 for $0
//   illegal               one-cycle pulse after an unsupported instr is accepted
//   fwd_en/fwd_reg/fwd_data  forwarding source (ALU_ISSUE_FWD_EN only)
module alu_issue_stage #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      aluc,
   output logic [4:0]      wr_reg,
   output logic            wr_en,
   output logic            illegal
`ifdef ALU_ISSUE_FWD_EN
   ,
   input  logic            fwd_en,
   input  logic [4:0]      fwd_reg,
   input  logic [XLEN-1:0] fwd_data
`endif
);

   localparam logic [3:0] ALUC_ADD = 4'b0000;
   localparam logic [3:0] ALUC_SUB = 4'b0100;
   localparam logic [3:0] ALUC_AND = 4'b0001;
   localparam logic [3:0] ALUC_OR  = 4'b0101;
   localparam logic [3:0] ALUC_XOR = 4'b0010;
   localparam logic [3:0] ALUC_LUI = 4'b0110;
   localparam logic [3:0] ALUC_SLL = 4'b0011;
   localparam logic [3:0] ALUC_SRL = 4'b0111;
   localparam logic [3:0] ALUC_SRA = 4'b1111;

   // One queue entry: {a, b, aluc, wr_reg, wr_en}
   localparam int EW = 2 * XLEN + 4 + 5 + 1;

   // Instruction fields
   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm;

   assign op    = instr[31:26];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];
   assign shamt = instr[10:6];
   assign funct = instr[5:0];
   assign imm   = instr[15:0];

   // Effective source operands (after optional forwarding)
   logic [XLEN-1:0] rs_eff;
   logic [XLEN-1:0] rt_eff;

`ifdef ALU_ISSUE_FWD_EN
   // Register $0 is never a forwarding target.
   assign rs_eff = (fwd_en && (fwd_reg != 5'd0) && (fwd_reg == rs)) ? fwd_data : rs_val;
   assign rt_eff = (fwd_en && (fwd_reg != 5'd0) && (fwd_reg == rt)) ? fwd_data : rt_val;
`else
   assign rs_eff = rs_val;
   assign rt_eff = rt_val;
`endif

   // Decode
   logic            legal;
   logic [3:0]      dec_aluc;
   logic [XLEN-1:0] dec_a;
   logic [XLEN-1:0] dec_b;
   logic [4:0]      dec_dest;

   always_comb begin
      legal    = 1'b0;
      dec_aluc = ALUC_ADD;
      dec_a    = rs_eff;
      dec_b    = rt_eff;
      dec_dest = rd;
      case (op)
         6'h00: begin
            case (funct)
               6'h20, 6'h21: begin legal = 1'b1; dec_aluc = ALUC_ADD; end
               6'h22, 6'h23: begin legal = 1'b1; dec_aluc = ALUC_SUB; end
               6'h24:        begin legal = 1'b1; dec_aluc = ALUC_AND; end
               6'h25:        begin legal = 1'b1; dec_aluc = ALUC_OR;  end
               6'h26:        begin legal = 1'b1; dec_aluc = ALUC_XOR; end
               6'h00, 6'h02, 6'h03: begin
                  legal = 1'b1;
                  // Shift amount travels on operand a; shifted value is rt.
                  dec_a = {{(XLEN-5){1'b0}}, shamt};
                  if (funct == 6'h00)      dec_aluc = ALUC_SLL;
                  else if (funct == 6'h02) dec_aluc = ALUC_SRL;
                  else                     dec_aluc = ALUC_SRA;
               end
               default: legal = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin
            legal    = 1'b1;
            dec_aluc = ALUC_ADD;
            dec_b    = {{(XLEN-16){imm[15]}}, imm};
            dec_dest = rt;
         end
         6'h0C, 6'h0D, 6'h0E: begin
            legal    = 1'b1;
            dec_b    = {{(XLEN-16){1'b0}}, imm};
            dec_dest = rt;
            if (op == 6'h0C)      dec_aluc = ALUC_AND;
            else if (op == 6'h0D) dec_aluc = ALUC_OR;
            else                  dec_aluc = ALUC_XOR;
         end
         6'h0F: begin
            legal    = 1'b1;
            dec_aluc = ALUC_LUI;
            dec_a    = '0;
            dec_b    = {{(XLEN-16){1'b0}}, imm};
            dec_dest = rt;
         end
         default: legal = 1'b0;
      endcase
   end

   // Queue control
   logic       head_reg;
   logic       tail_reg;
   logic [1:0] count_reg;
   logic [1:0] count_next;
   logic       illegal_reg;
   logic       accept;
   logic       push;
   logic       pop;
   logic [EW-1:0] entry_next;
   logic [EW-1:0] entry_arr [DEPTH];

   assign in_ready   = (count_reg < 2'd2);
   assign out_valid  = (count_reg != 2'd0);
   assign accept     = in_valid && in_ready;
   // Illegal instructions complete the handshake but never occupy a slot.
   assign push       = accept && legal;
   assign pop        = out_valid && out_ready;
   assign entry_next = {dec_a, dec_b, dec_aluc, dec_dest, (dec_dest != 5'd0)};

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_reg    <= 1'b0;
         tail_reg    <= 1'b0;
         count_reg   <= 2'd0;
         illegal_reg <= 1'b0;
      end else begin
         if (push) tail_reg <= ~tail_reg;
         if (pop)  head_reg <= ~head_reg;
         count_reg   <= count_next;
         illegal_reg <= accept && !legal;
      end
   end

   // Entry storage: payload only, no reset needed since out_valid gates reads.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [EW-1:0] entry_reg;
         always_ff @(posedge clk) begin
            if (push && (tail_reg == 1'(gi))) entry_reg <= entry_next;
         end
         assign entry_arr[gi] = entry_reg;
      end
   endgenerate

   // Outputs read as zero whenever the queue is empty (including after reset).
   assign {alu_a, alu_b, aluc, wr_reg, wr_en} = out_valid ? entry_arr[head_reg] : '0;
   assign illegal = illegal_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
// Directed-vector bench for alu_issue_stage. The driver pushes the expected
// ALU operation into a scoreboard queue when an instruction is accepted. A
// monitor compares the queue head at every falling edge where out_valid is
// high. It pops the entry when out_ready also consumes it.
// Define ALU_ISSUE_FWD_EN to include the forwarding vectors.
module tb_alu_issue_stage;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  aluc;
      logic [4:0]  wr_reg;
      logic        wr_en;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  aluc;
   logic [4:0]  wr_reg;
   logic        wr_en;
   logic        illegal;
`ifdef ALU_ISSUE_FWD_EN
   logic        fwd_en;
   logic [4:0]  fwd_reg;
   logic [31:0] fwd_data;
`endif

   int   checks = 0;
   int   errors = 0;
   int   exp_illegal = 0;
   int   seen_illegal = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .aluc      (aluc),
      .wr_reg    (wr_reg),
      .wr_en     (wr_en),
      .illegal   (illegal)
`ifdef ALU_ISSUE_FWD_EN
      ,
      .fwd_en    (fwd_en),
      .fwd_reg   (fwd_reg),
      .fwd_data  (fwd_data)
`endif
   );

   function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] c, input logic [4:0] r, input logic w);
      exp_t e;
      e.a = a; e.b = b; e.aluc = c; e.wr_reg = r; e.wr_en = w;
      return e;
   endfunction

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (illegal === 1'b1) seen_illegal++;
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got a=%h b=%h aluc=%b expected no output",
                     alu_a, alu_b, aluc);
         end else begin
            mon_e = exp_q[0];
            chk(out_ready ? "pop_entry" : "held_entry",
                {6'd0, alu_a, alu_b, aluc, wr_reg, wr_en}, {6'd0, mon_e});
            if (out_ready) begin
               $display("pop a=%h b=%h aluc=%b wr_reg=%0d wr_en=%0b",
                        alu_a, alu_b, aluc, wr_reg, wr_en);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Call just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                       input bit legal, input exp_t e);
      int waited = 0;
      instr    = ins;
      rs_val   = rs;
      rt_val   = rt;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 for instr %h", ins);
      end else if (legal) begin
         exp_q.push_back(e);
      end else begin
         exp_illegal++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      instr     = 32'h0;
      rs_val    = 32'h0;
      rt_val    = 32'h0;
`ifdef ALU_ISSUE_FWD_EN
      fwd_en    = 1'b0;
      fwd_reg   = 5'd0;
      fwd_data  = 32'h0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {6'd0, alu_a, alu_b, aluc, wr_reg, wr_en}, 80'd0);
      chk("reset_flags", {77'd0, out_valid, illegal, in_ready}, {77'd0, 3'b001});
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // add $3,$1,$2: presented the cycle after acceptance
      send(32'h00221820, 32'd1, 32'd2, 1'b1, mk(32'd1, 32'd2, 4'b0000, 5'd3, 1'b1));
      @(negedge clk);
      chk("add_latency", {79'd0, out_valid}, 80'd1);
      @(posedge clk);
      #1;

      // Streamed decode vectors
      send(32'h000523C0, 32'h0000DEAD, 32'hFFFFFFFF, 1'b1, mk(32'h0000000F, 32'hFFFFFFFF, 4'b0011, 5'd4, 1'b1));
      send(32'h3C01ABCD, 32'h00001234, 32'h00009999, 1'b1, mk(32'h0, 32'h0000ABCD, 4'b0110, 5'd1, 1'b1));
      send(32'h2002FFFF, 32'h00000010, 32'h0, 1'b1, mk(32'h10, 32'hFFFFFFFF, 4'b0000, 5'd2, 1'b1));
      send(32'h3002FFFF, 32'hF0F0F0F0, 32'h0, 1'b1, mk(32'hF0F0F0F0, 32'h0000FFFF, 4'b0001, 5'd2, 1'b1));
      send(32'h00C72822, 32'd100, 32'd30, 1'b1, mk(32'd100, 32'd30, 4'b0100, 5'd5, 1'b1));
      send(32'h000947C3, 32'h0, 32'h80000000, 1'b1, mk(32'd31, 32'h80000000, 4'b1111, 5'd8, 1'b1));
      send(32'h396A8000, 32'h11111111, 32'h0, 1'b1, mk(32'h11111111, 32'h00008000, 4'b0010, 5'd10, 1'b1));
      send(32'h00430825, 32'hA, 32'h5, 1'b1, mk(32'hA, 32'h5, 4'b0101, 5'd1, 1'b1));
      send(32'h00020902, 32'h0, 32'hF0, 1'b1, mk(32'd4, 32'hF0, 4'b0111, 5'd1, 1'b1));
      send(32'h00221821, 32'd7, 32'd8, 1'b1, mk(32'd7, 32'd8, 4'b0000, 5'd3, 1'b1));
      send(32'h34078001, 32'd3, 32'h0, 1'b1, mk(32'd3, 32'h00008001, 4'b0101, 5'd7, 1'b1));
      send(32'h00220020, 32'd9, 32'd6, 1'b1, mk(32'd9, 32'd6, 4'b0000, 5'd0, 1'b0));
      wait_empty();

      // Illegal instructions: accepted, one-cycle pulse, nothing queued
      send(32'hFC000000, 32'h0, 32'h0, 1'b0, '0);
      @(negedge clk);
      chk("illegal_pulse", {78'd0, illegal, out_valid}, {78'd0, 2'b10});
      @(negedge clk);
      chk("illegal_cleared", {78'd0, illegal, out_valid}, {78'd0, 2'b00});
      @(posedge clk);
      #1;
      send(32'h0000002A, 32'h1, 32'h2, 1'b0, '0);
      @(negedge clk);
      chk("illegal_funct_pulse", {79'd0, illegal}, 80'd1);
      @(posedge clk);
      #1;

      // Backpressure: two fill the queue, third waits until out_ready rises
      out_ready = 1'b0;
      send(32'h00221820, 32'h100, 32'h200, 1'b1, mk(32'h100, 32'h200, 4'b0000, 5'd3, 1'b1));
      send(32'h00C72822, 32'h300, 32'h400, 1'b1, mk(32'h300, 32'h400, 4'b0100, 5'd5, 1'b1));
      @(negedge clk);
      chk("full_in_ready", {79'd0, in_ready}, 80'd0);
      fork
         send(32'h3C01BEEF, 32'h0, 32'h0, 1'b1, mk(32'h0, 32'h0000BEEF, 4'b0110, 5'd1, 1'b1));
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_empty();

      // Simultaneous push and pop at count=1 keeps one entry
      out_ready = 1'b0;
      send(32'h00430825, 32'h1, 32'h2, 1'b1, mk(32'h1, 32'h2, 4'b0101, 5'd1, 1'b1));
      out_ready = 1'b1;
      send(32'h3002FFFF, 32'h5, 32'h0, 1'b1, mk(32'h5, 32'h0000FFFF, 4'b0001, 5'd2, 1'b1));
      @(negedge clk);
      chk("push_pop_count1", {78'd0, in_ready, out_valid}, {78'd0, 2'b11});
      @(posedge clk);
      #1;
      wait_empty();

`ifdef ALU_ISSUE_FWD_EN
      fwd_en   = 1'b1;
      fwd_reg  = 5'd1;
      fwd_data = 32'h55;
      send(32'h00221820, 32'd1, 32'd2, 1'b1, mk(32'h55, 32'd2, 4'b0000, 5'd3, 1'b1));
      fwd_reg  = 5'd5;
      send(32'h000523C0, 32'h0, 32'hFFFFFFFF, 1'b1, mk(32'h0000000F, 32'h55, 4'b0011, 5'd4, 1'b1));
      fwd_reg  = 5'd0;
      send(32'h00021820, 32'd7, 32'd2, 1'b1, mk(32'd7, 32'd2, 4'b0000, 5'd3, 1'b1));
      fwd_en   = 1'b0;
      fwd_reg  = 5'd1;
      send(32'h00221820, 32'd1, 32'd2, 1'b1, mk(32'd1, 32'd2, 4'b0000, 5'd3, 1'b1));
      wait_empty();
`endif

      // Reset with two entries queued discards them
      out_ready = 1'b0;
      send(32'h00221820, 32'h11, 32'h22, 1'b1, mk(32'h11, 32'h22, 4'b0000, 5'd3, 1'b1));
      send(32'h00C72822, 32'h33, 32'h44, 1'b1, mk(32'h33, 32'h44, 4'b0100, 5'd5, 1'b1));
      @(negedge clk);
      chk("prereset_full", {78'd0, in_ready, out_valid}, {78'd0, 2'b01});
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("midreset_flags", {78'd0, in_ready, out_valid}, {78'd0, 2'b10});
      repeat (3) @(negedge clk);

      chk("scoreboard_empty", 80'(exp_q.size()), 80'd0);
      chk("illegal_count", 80'(seen_illegal), 80'(exp_illegal));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
